uart_rx_os16: RTL and testbench



---
 rtl/uart_rx_os16_pkg.sv | 21 ++
 rtl/uart_os_tick_gen.sv | 31 +++
 rtl/uart_rx_os16.sv | 146 ++++++++++++++
 tb/tb_uart_rx_os16.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_os16_pkg.sv
// Shared definitions for the 16x-oversampling UART receive path.
// State encoding, frame constants and the oversample divider computation.
package uart_rx_os16_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // Clocks per oversample tick, truncated (27 for 50 MHz / 115200 / 16).
    function automatic int uart_div(input int clk_freq, input int baud, input int os);
        return clk_freq / (baud * os);
    endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversample tick divider: counts 0..DIV-1 and pulses o_os_tick on the last count.
// i_clear restarts the count so the tick phase can be re-aligned to a line edge.
module uart_os_tick_gen
    import uart_rx_os16_pkg::*;
#(
    parameter int DIV = uart_div(50000000, 115200, UART_OVERSAMPLE)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_os_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_div_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (i_clear || (r_div_cnt == LAST)) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign o_os_tick = (r_div_cnt == LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// 16x-oversampling 8N1 UART receiver, LSB first, with start-bit qualification,
// mid-bit sampling and one-cycle valid / frame_err strobes.
module uart_rx_os16
    import uart_rx_os16_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic                      r_sync1, r_sync2, r_rx_d;
    rx_state_t                 r_state, w_state_nxt;
    logic [3:0]                r_s, w_s_nxt;
    logic [2:0]                r_bit_idx, w_bit_nxt;
    logic [UART_DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [7:0]                r_data, w_data_nxt;
    logic                      r_valid, w_valid_nxt;
    logic                      r_ferr, w_ferr_nxt;
    logic                      w_clear, w_tick, w_start_edge;

    // Synchronizer resets to the idle line level so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_rx_d  <= r_sync2;
        end
    end

    assign w_start_edge = r_rx_d & ~r_sync2;

    uart_os_tick_gen #(.DIV(DIV)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .o_os_tick(w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_s       <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_s       <= w_s_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_ferr    <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt = ST_START;
                    w_clear     = 1'b1;
                    w_s_nxt     = '0;
                end
            end
            ST_START: begin
                // Eighth tick after the edge lands mid start bit.
                if (w_tick) begin
                    if (r_s == 4'd7) begin
                        w_s_nxt   = '0;
                        w_bit_nxt = '0;
                        w_state_nxt = r_sync2 ? ST_IDLE : ST_DATA;
                    end else begin
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_s_nxt = r_s + 4'd1;
                    if (r_s == 4'd15) begin
                        w_shift_nxt = {r_sync2, r_shift[UART_DATA_BITS-1:1]};
                        w_bit_nxt   = r_bit_idx + 3'd1;
                        if (r_bit_idx == LAST_BIT) begin
                            w_state_nxt = ST_STOP;
                        end
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_s_nxt = r_s + 4'd1;
                    if (r_s == 4'd15) begin
                        if (r_sync2) begin
                            w_data_nxt  = r_shift;
                            w_valid_nxt = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = ST_BREAK;
                        end
                    end
                end
            end
            ST_BREAK: begin
                if (r_sync2) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: frames are built from their bit-level
// definition and the received bytes/pulses are compared with the expected list.
module tb_uart_rx_os16;

    localparam int BIT_CLKS = 432;
    localparam int LATENCY  = 4107;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_fall = 0;
    int n_valid = 0;
    int n_ferr  = 0;
    int n_both  = 0;
    logic [7:0] last_good = 8'h00;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         obs_cyc_q[$];

    uart_rx_os16 dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            obs_q.push_back(data);
            obs_cyc_q.push_back(cyc);
        end
        if (frame_err) n_ferr++;
        if (valid && frame_err) n_both++;
    end

    // Reference: a good frame yields its byte; a low stop bit yields no byte.
    function automatic void model_expect(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) begin
            exp_q.push_back(b);
            last_good = b;
        end
    endfunction

    // Called at a negedge; drives start, 8 data bits LSB first, stop. Leaves rxd at stop level.
    task automatic send_frame(input logic [7:0] b, input int bl, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        model_expect(b, stop_bit);
        last_fall = cyc;
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (bl) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total += 4;
        if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %02h expected 00", data); end
        if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", valid); end
        if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        idle(10);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single;
        int v0, f0, lat;
        logic [7:0] e, o;
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h05, BIT_CLKS, 1'b1);
        idle(20);
        total += 2;
        if (n_valid - v0 !== 1) begin bad++; $display("FAIL single_count: got %0d expected 1", n_valid - v0); end
        if (n_ferr !== f0) begin bad++; $display("FAIL single_ferr: got %0d expected %0d", n_ferr, f0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL single_data: got none expected %02h", e);
            end else begin
                o = obs_q.pop_front();
                lat = obs_cyc_q.pop_front() - last_fall;
                if (o !== e) begin bad++; $display("FAIL single_data: got %02h expected %02h", o, e); end
                total++;
                if (lat < LATENCY - 1 || lat > LATENCY + 1) begin
                    bad++; $display("FAIL single_latency: got %0d expected %0d+-1", lat, LATENCY);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int v0;
        logic [7:0] e, o;
        v0 = n_valid;
        send_frame(8'hA5, BIT_CLKS, 1'b1);
        send_frame(8'h00, BIT_CLKS, 1'b1);
        send_frame(8'hFF, BIT_CLKS, 1'b1);
        idle(20);
        total++;
        if (n_valid - v0 !== 3) begin bad++; $display("FAIL b2b_count: got %0d expected 3", n_valid - v0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL b2b_data: got none expected %02h", e);
            end else begin
                o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
                if (o !== e) begin bad++; $display("FAIL b2b_data: got %02h expected %02h", o, e); end
            end
        end
    endtask

    task automatic test_false_start;
        int v0, f0;
        logic [7:0] e, o;
        v0 = n_valid; f0 = n_ferr;
        rxd = 1'b0;
        repeat (50) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_high: got %b expected 1", busy); end
        repeat (50) @(negedge clk);
        idle(250);
        total += 3;
        if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_low: got %b expected 0", busy); end
        if (n_valid !== v0) begin bad++; $display("FAIL glitch_valid: got %0d expected %0d", n_valid, v0); end
        if (n_ferr !== f0) begin bad++; $display("FAIL glitch_ferr: got %0d expected %0d", n_ferr, f0); end
        send_frame(8'h3C, BIT_CLKS, 1'b1);
        idle(20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL glitch_next_data: got none expected %02h", e);
            end else begin
                o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
                if (o !== e) begin bad++; $display("FAIL glitch_next_data: got %02h expected %02h", o, e); end
            end
        end
    endtask

    task automatic test_frame_err;
        int v0, f0;
        logic [7:0] e, o, held;
        v0 = n_valid; f0 = n_ferr; held = last_good;
        send_frame(8'h81, BIT_CLKS, 1'b0);
        repeat (2000 - BIT_CLKS) @(negedge clk);
        total += 4;
        if (n_ferr - f0 !== 1) begin bad++; $display("FAIL ferr_count: got %0d expected 1", n_ferr - f0); end
        if (n_valid !== v0) begin bad++; $display("FAIL ferr_valid: got %0d expected %0d", n_valid, v0); end
        if (data !== held) begin bad++; $display("FAIL ferr_data_held: got %02h expected %02h", data, held); end
        if (busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_break: got %b expected 1", busy); end
        idle(10);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy_release: got %b expected 0", busy); end
        idle(20);
        send_frame(8'h42, BIT_CLKS, 1'b1);
        idle(20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL ferr_next_data: got none expected %02h", e);
            end else begin
                o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
                if (o !== e) begin bad++; $display("FAIL ferr_next_data: got %02h expected %02h", o, e); end
            end
        end
    endtask

    task automatic test_reset_mid;
        int v0, f0;
        logic [9:0] f;
        logic [7:0] e, o;
        f = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rxd = f[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rxd = f[5];
        repeat (BIT_CLKS / 2) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
        v0 = n_valid; f0 = n_ferr;
        rst = 1'b1;
        last_good = 8'h00;
        #1;
        total += 4;
        if (data !== 8'h00) begin bad++; $display("FAIL rstmid_data: got %02h expected 00", data); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        if (valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b expected 0", valid); end
        if (frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_ferr: got %b expected 0", frame_err); end
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        idle(500);
        total += 2;
        if (n_valid !== v0) begin bad++; $display("FAIL rstmid_no_valid: got %0d expected %0d", n_valid, v0); end
        if (n_ferr !== f0) begin bad++; $display("FAIL rstmid_no_ferr: got %0d expected %0d", n_ferr, f0); end
        send_frame(8'h5A, BIT_CLKS, 1'b1);
        idle(20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL rstmid_next_data: got none expected %02h", e);
            end else begin
                o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
                if (o !== e) begin bad++; $display("FAIL rstmid_next_data: got %02h expected %02h", o, e); end
            end
        end
    endtask

    task automatic test_baud_offset;
        int f0;
        logic [7:0] e, o;
        f0 = n_ferr;
        send_frame(8'h55, BIT_CLKS + (BIT_CLKS * 3) / 100, 1'b1);
        idle(20);
        send_frame(8'hC3, BIT_CLKS - (BIT_CLKS * 3) / 100, 1'b1);
        idle(20);
        total++;
        if (n_ferr !== f0) begin bad++; $display("FAIL baud_ferr: got %0d expected %0d", n_ferr, f0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL baud_data: got none expected %02h", e);
            end else begin
                o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
                if (o !== e) begin bad++; $display("FAIL baud_data: got %02h expected %02h", o, e); end
            end
        end
    endtask

    task automatic test_random;
        int f0, pct, bl;
        logic [7:0] b, e, o;
        f0 = n_ferr;
        for (int k = 0; k < 4; k++) begin
            b   = 8'($urandom_range(255, 0));
            pct = int'($urandom_range(6, 0)) - 3;
            bl  = BIT_CLKS + (BIT_CLKS * pct) / 100;
            send_frame(b, bl, 1'b1);
            idle(int'($urandom_range(40, 0)));
        end
        idle(20);
        total++;
        if (n_ferr !== f0) begin bad++; $display("FAIL rand_ferr: got %0d expected %0d", n_ferr, f0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL rand_data: got none expected %02h", e);
            end else begin
                o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
                if (o !== e) begin bad++; $display("FAIL rand_data: got %02h expected %02h", o, e); end
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL rand_extra: got %0d expected 0 leftover bytes", obs_q.size()); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_false_start();
        test_frame_err();
        test_reset_mid();
        test_baud_offset();
        test_random();
        total++;
        if (n_both !== 0) begin bad++; $display("FAIL valid_ferr_overlap: got %0d expected 0", n_both); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
